// File: rtl/hgcal_quant_pkg.sv
// Shared types, default sizes and the cell quantizer for the HGCAL input stage.
// Consumed by hgcal_input_quantizer and hgcal_frame_buf.
package hgcal_quant_pkg;

  localparam int NUM_IN_DEF = 48;
  localparam int IN_W_DEF   = 16;
  localparam int QBITS_DEF  = 2;
  localparam int SHIFT_DEF  = 8;
  localparam int SAT_CNT_W  = 16;

  typedef logic [QBITS_DEF-1:0] code_t;

  // Shift first, then clamp anything that no longer fits in QBITS to all-ones.
  function automatic code_t quantize(input logic [IN_W_DEF-1:0] in, input int unsigned shift);
    logic [IN_W_DEF-1:0] v;
    v = in >> shift;
    if (v > IN_W_DEF'(2**QBITS_DEF - 1)) begin
      return '1;
    end
    return v[QBITS_DEF-1:0];
  endfunction

endpackage

// File: rtl/hgcal_frame_buf.sv
// Output stage: holds one packed frame and runs the m_valid/m_ready handshake.
// A load always wins over the handshake clear so back-to-back frames see no bubble.
module hgcal_frame_buf
  import hgcal_quant_pkg::*;
#(
  parameter int DW = NUM_IN_DEF * QBITS_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [DW-1:0] i_data,
  input  logic          i_m_ready,
  output logic          o_m_valid,
  output logic [DW-1:0] o_m_data
);

  logic          r_valid;
  logic [DW-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (i_load) begin
        r_valid <= 1'b1;
        r_data  <= i_data;
      end else if (r_valid && i_m_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_m_valid = r_valid;
  assign o_m_data  = r_data;

endmodule

// File: rtl/hgcal_input_quantizer.sv
// Cell-stream quantizer and frame packer feeding the layer-0 neuron LUTs.
// Optional saturation counter port sat_cnt is built when HGCAL_QUANT_SAT_CNT_EN is defined.
module hgcal_input_quantizer
  import hgcal_quant_pkg::*;
#(
  parameter int NUM_IN = NUM_IN_DEF,
  parameter int IN_W   = IN_W_DEF,
  parameter int QBITS  = QBITS_DEF,
  parameter int SHIFT  = SHIFT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [IN_W-1:0]         s_data,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [NUM_IN*QBITS-1:0] m_data,
  output logic                    frm_err
`ifdef HGCAL_QUANT_SAT_CNT_EN
  ,
  output logic [SAT_CNT_W-1:0]    sat_cnt
`endif
);

  localparam int DW    = NUM_IN * QBITS;
  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [IDX_W-1:0] r_idx;
  logic [DW-1:0]    r_acc;
  logic             r_frm_err;

  logic [IN_W-1:0]  w_shifted;
  logic             w_sat;
  logic [QBITS-1:0] w_code;
  logic [DW-1:0]    w_merged;
  logic             w_last_slot;
  logic             w_accept;
  logic             w_close;
  logic             w_out_busy;
  logic             w_m_valid;

  assign w_shifted = s_data >> SHIFT;
  assign w_sat     = (w_shifted > IN_W'((1 << QBITS) - 1));

  genvar gi;
  generate
    if (QBITS == QBITS_DEF && IN_W == IN_W_DEF) begin : g_pkg_quant
      assign w_code = quantize(s_data, SHIFT);
    end else begin : g_gen_quant
      assign w_code = w_sat ? {QBITS{1'b1}} : w_shifted[QBITS-1:0];
    end
  endgenerate

  // Slot k sits at the MSB end for k=0; the current code lands in slot r_idx.
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_slot
      assign w_merged[(NUM_IN-1-gi)*QBITS +: QBITS] =
        (r_idx == IDX_W'(gi)) ? w_code : r_acc[(NUM_IN-1-gi)*QBITS +: QBITS];
    end
  endgenerate

  assign w_last_slot = (r_idx == IDX_W'(NUM_IN - 1));
  assign w_out_busy  = w_m_valid && !m_ready;
  // An early s_last also closes a frame, so it must stall too while the output is held.
  assign s_ready     = !(w_out_busy && (w_last_slot || s_last));
  assign w_accept    = s_valid && s_ready;
  assign w_close     = w_accept && (w_last_slot || s_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_acc     <= '0;
      r_frm_err <= 1'b0;
    end else if (w_accept) begin
      if (w_close) begin
        r_idx <= '0;
        r_acc <= '0;
      end else begin
        r_idx <= r_idx + IDX_W'(1);
        r_acc <= w_merged;
      end
      if (s_last != w_last_slot) begin
        r_frm_err <= 1'b1;
      end
    end
  end

  assign frm_err = r_frm_err;

`ifdef HGCAL_QUANT_SAT_CNT_EN
  logic [SAT_CNT_W-1:0] r_sat_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_cnt <= '0;
    end else if (w_accept && w_sat && (r_sat_cnt != {SAT_CNT_W{1'b1}})) begin
      r_sat_cnt <= r_sat_cnt + SAT_CNT_W'(1);
    end
  end

  assign sat_cnt = r_sat_cnt;
`endif

  hgcal_frame_buf #(
    .DW (DW)
  ) u_frame_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_close),
    .i_data    (w_merged),
    .i_m_ready (m_ready),
    .o_m_valid (w_m_valid),
    .o_m_data  (m_data)
  );

  assign m_valid = w_m_valid;

endmodule

// File: tb/tb_hgcal_input_quantizer.sv
// Directed bench for hgcal_input_quantizer; sat_cnt is checked when HGCAL_QUANT_SAT_CNT_EN is defined.
module tb_hgcal_input_quantizer;
  localparam int DW = 96;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          m_ready = 1'b0;
  logic [15:0]   s_data = '0;
  logic          s_ready;
  logic          m_valid;
  logic          frm_err;
  logic [DW-1:0] m_data;
`ifdef HGCAL_QUANT_SAT_CNT_EN
  logic [15:0]   sat_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int stall_seen = 0;

  always #5 clk = ~clk;

  hgcal_input_quantizer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .frm_err (frm_err)
`ifdef HGCAL_QUANT_SAT_CNT_EN
    ,
    .sat_cnt (sat_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One beat presented from a falling edge; returns at the next falling edge.
  task automatic beat(input logic [15:0] d, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    #1;
    if (!s_ready) stall_seen++;
    @(negedge clk);
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
  endtask

  initial begin
    int first_v, second_v, pulses, stalls;
    logic [DW-1:0] d1, d2;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_frm_err", frm_err, 0);
`ifdef HGCAL_QUANT_SAT_CNT_EN
    chk("rst_sat_cnt", sat_cnt, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single frame, codes k mod 4
    m_ready = 1'b1;
    for (int k = 0; k < 48; k++) beat(16'h0100 * 16'(k % 4), k == 47);
    idle();
    chk("t1_m_valid", m_valid, 1);
    chk("t1_m_data", m_data, 96'h1b1b1b1b_1b1b1b1b_1b1b1b1b);
    chk("t1_frm_err", frm_err, 0);
    @(negedge clk);
    chk("t1_pulse_end", m_valid, 0);

    // 2: clamp high and truncation to zero
    for (int k = 0; k < 48; k++) beat(16'hFFFF, k == 47);
    idle();
    chk("t2_sat_data", m_data, 96'hffffffff_ffffffff_ffffffff);
`ifdef HGCAL_QUANT_SAT_CNT_EN
    chk("t2_sat_cnt", sat_cnt, 48);
`endif
    for (int k = 0; k < 48; k++) beat(16'h00FF, k == 47);
    idle();
    chk("t2_zero_data", m_data, 0);
    chk("t2_zero_valid", m_valid, 1);
`ifdef HGCAL_QUANT_SAT_CNT_EN
    chk("t2_sat_cnt_hold", sat_cnt, 48);
`endif
    @(negedge clk);

    // 3: backpressure, two full frames with m_ready low
    m_ready = 1'b0;
    for (int k = 0; k < 48; k++) beat(16'h0200, k == 47);
    idle();
    chk("t3_f1_valid", m_valid, 1);
    chk("t3_f1_data", m_data, 96'haaaaaaaa_aaaaaaaa_aaaaaaaa);
    stall_seen = 0;
    for (int k = 0; k < 47; k++) beat(16'h0100, 1'b0);
    chk("t3_no_early_stall", 96'(stall_seen), 0);
    s_valid = 1'b1; s_data = 16'h0100; s_last = 1'b1;
    #1;
    chk("t3_close_stall", s_ready, 0);
    repeat (3) @(negedge clk);
    chk("t3_f1_held", m_data, 96'haaaaaaaa_aaaaaaaa_aaaaaaaa);
    chk("t3_f1_held_valid", m_valid, 1);
    m_ready = 1'b1;
    #1;
    chk("t3_release_ready", s_ready, 1);
    @(negedge clk);
    idle();
    chk("t3_f2_valid", m_valid, 1);
    chk("t3_f2_data", m_data, 96'h55555555_55555555_55555555);
    @(negedge clk);
    chk("t3_drain", m_valid, 0);
    chk("t3_frm_err", frm_err, 0);

    // 4: continuous input with m_ready high
    first_v = -1; second_v = -1; pulses = 0; stalls = 0; d1 = '0; d2 = '0;
    for (int i = 0; i < 96; i++) begin
      s_valid = 1'b1;
      s_last  = ((i % 48) == 47);
      s_data  = (i < 48) ? (((i % 2) == 0) ? 16'h0300 : 16'h0000) : 16'h02A5;
      #1;
      if (!s_ready) stalls++;
      @(negedge clk);
      if (m_valid) begin
        pulses++;
        if (first_v < 0) begin first_v = i; d1 = m_data; end
        else if (second_v < 0) begin second_v = i; d2 = m_data; end
      end
    end
    idle();
    chk("t4_stalls", 96'(stalls), 0);
    chk("t4_pulses", 96'(pulses), 2);
    chk("t4_spacing", 96'(second_v - first_v), 48);
    chk("t4_frame_c", d1, 96'hcccccccc_cccccccc_cccccccc);
    chk("t4_frame_d", d2, 96'haaaaaaaa_aaaaaaaa_aaaaaaaa);
    @(negedge clk);

    // 5: short frame closed by s_last on beat 9, clamp boundary on cells 0/1
    beat(16'h03FF, 1'b0);
    beat(16'h0400, 1'b0);
    for (int k = 2; k < 10; k++) beat(16'h0100, k == 9);
    idle();
    chk("t5_valid", m_valid, 1);
    chk("t5_data", m_data, 96'hf5555000_00000000_00000000);
    chk("t5_frm_err", frm_err, 1);
`ifdef HGCAL_QUANT_SAT_CNT_EN
    chk("t5_sat_cnt", sat_cnt, 49);
`endif
    for (int k = 0; k < 48; k++) beat((k == 0) ? 16'h0300 : 16'h0100, k == 47);
    idle();
    chk("t5_next_data", m_data, 96'hd5555555_55555555_55555555);
    @(negedge clk);

    // 6: reset mid-frame with a pending output
    m_ready = 1'b0;
    for (int k = 0; k < 48; k++) beat(16'h0300, k == 47);
    for (int k = 0; k < 20; k++) beat(16'h0100, 1'b0);
    idle();
    rst_n = 1'b0;
    #1;
    chk("t6_s_ready", s_ready, 1);
    chk("t6_m_valid", m_valid, 0);
    chk("t6_m_data", m_data, 0);
    chk("t6_frm_err", frm_err, 0);
`ifdef HGCAL_QUANT_SAT_CNT_EN
    chk("t6_sat_cnt", sat_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 48; k++) beat(16'h0100 * 16'(k % 4), k == 47);
    idle();
    chk("t6_clean_valid", m_valid, 1);
    chk("t6_clean_data", m_data, 96'h1b1b1b1b_1b1b1b1b_1b1b1b1b);
    chk("t6_clean_err", frm_err, 0);
    @(negedge clk);

    // Full frame without s_last, then a lone cell starts a new frame
    for (int k = 0; k < 48; k++) beat(16'h0200, 1'b0);
    idle();
    chk("t7_nolast_valid", m_valid, 1);
    chk("t7_nolast_data", m_data, 96'haaaaaaaa_aaaaaaaa_aaaaaaaa);
    chk("t7_nolast_err", frm_err, 1);
    beat(16'h0300, 1'b1);
    idle();
    chk("t7_lone_data", m_data, 96'hc0000000_00000000_00000000);
    chk("t7_lone_valid", m_valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
